iomem_line_bridge: RTL and testbench

- Sits directly downstream of the core's iomem port, between the core and the on-chip SRAM/peripheral bus.
- Takes one cache-line request (BLK_SIZE bits, per-byte write strobe) and serialises it into WORD_W-bit beats on a pipelined req/gnt/rvalid word bus.
- Read beats are assembled back into a full line, which is returned with a one-cycle iomem_ready pulse.
- Supports up to MAX_OUTST beats in flight.

---
 rtl/tcore_param.sv | 34 +++
 rtl/iomem_line_bridge.sv | 160 ++++++++++++++++
 tb/tb_iomem_line_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcore_param.sv
// Shared definitions for the core-side memory bridges.
//   XLEN / WORD_W / BEATS / MAX_OUTST : default geometry of the word bus
//   word_bus_req_t : one word-bus request beat (req, we, be, addr, wdata)
//   word_bus_res_t : one word-bus response (rvalid, rdata)
//   bridge_state_e : line bridge sequencing states
package tcore_param;

  localparam int XLEN      = 32;
  localparam int WORD_W    = 32;
  localparam int BEATS     = 4;
  localparam int MAX_OUTST = 2;
  localparam int BE_W      = WORD_W / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   addr;
    logic [WORD_W-1:0] wdata;
  } word_bus_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [WORD_W-1:0] rdata;
  } word_bus_res_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/iomem_line_bridge.sv
// Cache-line to word-bus bridge.
// Accepts one BLK_SIZE-bit line request from the core iomem port, splits it
// into WORD_W-bit beats on a pipelined req/gnt/rvalid bus (at most MAX_OUTST
// granted-but-unanswered beats), reassembles read beats into a line and
// returns it with a single-cycle iomem_ready_o pulse.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   iomem_valid_i         line request valid, held until ready
//   iomem_ready_o         one-cycle completion pulse
//   iomem_addr_i          line address (offset bits ignored)
//   iomem_wstrb_i         per-byte write strobes, all-zero means read
//   iomem_wdata_i         write line
//   iomem_rdata_o         read line, valid while ready is high (0 for writes)
//   bus_req_o/bus_gnt_i   word request / accepted this cycle
//   bus_we_o, bus_be_o    write flag, byte enables
//   bus_addr_o            word address
//   bus_wdata_o           write word
//   bus_rvalid_i          in-order response, one per granted beat
//   bus_rdata_i           read word
module iomem_line_bridge #(
  parameter int XLEN             = tcore_param::XLEN,
  parameter int WORD_W           = tcore_param::WORD_W,
  parameter int BLK_SIZE         = tcore_param::BEATS * tcore_param::WORD_W,
  parameter int MAX_OUTST        = tcore_param::MAX_OUTST,
  parameter int SKIP_EMPTY_BEATS = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    iomem_valid_i,
  output logic                    iomem_ready_o,
  input  logic [XLEN-1:0]         iomem_addr_i,
  input  logic [BLK_SIZE/8-1:0]   iomem_wstrb_i,
  input  logic [BLK_SIZE-1:0]     iomem_wdata_i,
  output logic [BLK_SIZE-1:0]     iomem_rdata_o,
  output logic                    bus_req_o,
  input  logic                    bus_gnt_i,
  output logic                    bus_we_o,
  output logic [WORD_W/8-1:0]     bus_be_o,
  output logic [XLEN-1:0]         bus_addr_o,
  output logic [WORD_W-1:0]       bus_wdata_o,
  input  logic                    bus_rvalid_i,
  input  logic [WORD_W-1:0]       bus_rdata_i
);

  import tcore_param::*;

  localparam int BEATS_L = BLK_SIZE / WORD_W;
  localparam int BE_W_L  = WORD_W / 8;
  localparam int CNT_W   = $clog2(BEATS_L) + 1;   // holds BEATS without wrapping
  localparam int OFF_W   = $clog2(BE_W_L);
  localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS_L);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_OUTST);
  localparam logic [XLEN-1:0]  LINE_MASK = ~(XLEN'(BEATS_L * BE_W_L) - XLEN'(1));

  bridge_state_e state_q, state_d;

  logic [CNT_W-1:0]      issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]      resp_idx_q;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic                  is_write_q;
  logic [XLEN-1:0]       line_addr_q;
  logic [BLK_SIZE/8-1:0] wstrb_q;
  logic [BLK_SIZE-1:0]   wdata_q;
  logic [BLK_SIZE-1:0]   rbuf_q;

  logic [CNT_W-2:0]      slot;
  logic [BE_W_L-1:0]     cur_be;
  logic                  skip_beat;
  logic                  grant_fire;
  logic                  rsp_fire;

  // Slicing uses only the low index bits; the top bit is set only once every
  // beat has been issued, when the request outputs are gated off anyway.
  assign slot   = issue_idx_q[CNT_W-2:0];
  assign cur_be = wstrb_q[slot*BE_W_L +: BE_W_L];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bus_req_o = 1'b0;
    skip_beat = 1'b0;

    if (state_q == ISSUE && issue_idx_q < BEATS_C) begin
      if (is_write_q && SKIP_EMPTY_BEATS != 0 && cur_be == '0) begin
        skip_beat = 1'b1;
      end else begin
        bus_req_o = (outst_q < MAX_C);
      end
    end

    grant_fire = bus_req_o & bus_gnt_i;
    // Responses are only meaningful while a line is in flight; after a reset
    // outstanding is zero, so late answers from the abandoned line drop out.
    rsp_fire   = bus_rvalid_i && (state_q == ISSUE || state_q == DRAIN) && (outst_q != '0);

    issue_idx_d = issue_idx_q + CNT_W'(skip_beat | grant_fire);
    outst_d     = outst_q + CNT_W'(grant_fire) - CNT_W'(rsp_fire);

    unique case (state_q)
      IDLE:  if (iomem_valid_i)          state_d = ISSUE;
      ISSUE: if (issue_idx_d == BEATS_C) state_d = DRAIN;
      // Looking at the post-update count lets the last response and the
      // move to RESP share a cycle, giving the 2+BEATS minimum latency.
      DRAIN: if (outst_d == '0)          state_d = RESP;
      RESP:                              state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  assign bus_we_o      = bus_req_o & is_write_q;
  assign bus_be_o      = bus_req_o ? (is_write_q ? cur_be : '1) : '0;
  assign bus_addr_o    = bus_req_o ? (line_addr_q | (XLEN'(slot) << OFF_W)) : '0;
  assign bus_wdata_o   = bus_req_o ? wdata_q[slot*WORD_W +: WORD_W] : '0;
  assign iomem_ready_o = (state_q == RESP);
  assign iomem_rdata_o = (state_q == RESP && !is_write_q) ? rbuf_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      resp_idx_q  <= '0;
      outst_q     <= '0;
      is_write_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (state_q == IDLE) begin
        issue_idx_q <= '0;
        resp_idx_q  <= '0;
        if (iomem_valid_i) is_write_q <= |iomem_wstrb_i;
      end else begin
        issue_idx_q <= issue_idx_d;
        if (rsp_fire && !is_write_q) resp_idx_q <= resp_idx_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the line buffers carry no reset; every output they feed is gated by
  // the FSM state, and a new request overwrites them before they are used.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && iomem_valid_i) begin
      line_addr_q <= iomem_addr_i & LINE_MASK;
      wstrb_q     <= iomem_wstrb_i;
      wdata_q     <= iomem_wdata_i;
    end
    if (rsp_fire && !is_write_q) begin
      rbuf_q[resp_idx_q*WORD_W +: WORD_W] <= bus_rdata_i;
    end
  end

  // A response with nothing outstanding during a transfer is a bus protocol
  // violation; it is dropped, but should never happen.
  stray_rvalid_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus_rvalid_i && (state_q == ISSUE || state_q == DRAIN)) |-> (outst_q != '0));

endmodule

// File: tb/tb_iomem_line_bridge.sv
module tb_iomem_line_bridge;

  localparam int MAX_OUTST = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         iomem_valid_i = 1'b0;
  logic         iomem_ready_o;
  logic [31:0]  iomem_addr_i = '0;
  logic [15:0]  iomem_wstrb_i = '0;
  logic [127:0] iomem_wdata_i = '0;
  logic [127:0] iomem_rdata_o;
  logic         bus_req_o;
  logic         bus_gnt_i = 1'b0;
  logic         bus_we_o;
  logic [3:0]   bus_be_o;
  logic [31:0]  bus_addr_o;
  logic [31:0]  bus_wdata_o;
  logic         bus_rvalid_i = 1'b0;
  logic [31:0]  bus_rdata_i = '0;

  iomem_line_bridge dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .iomem_valid_i (iomem_valid_i),
    .iomem_ready_o (iomem_ready_o),
    .iomem_addr_i  (iomem_addr_i),
    .iomem_wstrb_i (iomem_wstrb_i),
    .iomem_wdata_i (iomem_wdata_i),
    .iomem_rdata_o (iomem_rdata_o),
    .bus_req_o     (bus_req_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int checks   = 0;
  int failures = 0;
  logic [127:0] last_rdata;

  logic [198:0] all_outs;
  assign all_outs = {iomem_ready_o, iomem_rdata_o, bus_req_o, bus_we_o,
                     bus_be_o, bus_addr_o, bus_wdata_o};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag, input int obs, input int exp);
    checks++;
    failures++;
    $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      iomem_valid_i = 1'b0;
      bus_gnt_i     = 1'b0;
      bus_rvalid_i  = 1'b0;
    end
  endtask

  // One line transaction. Expected beats come from the strobes (one per word,
  // empty write words dropped); expected read line is the responses in order.
  // gnt_mode: 0 always grant, 1 random grant, 2 hold off beat 2 for 3 cycles.
  // rv_extra: extra response delay after the grant cycle (-1 = random 0..2).
  task automatic run_line(input logic [31:0] addr, input logic [15:0] strb,
                          input logic [127:0] wd, input int gnt_mode,
                          input int rv_extra, input bit fixed_data,
                          input int exp_lat, input int out_lim, input int abort_after);
    beat_t        expq[$];
    rsp_t         pend[$];
    beat_t        cur;
    beat_t        prev;
    rsp_t         r;
    logic [127:0] exp_line;
    logic [3:0]   s;
    int  rk, grants, n_beats, out_cnt, max_out, stall_n, ex, cyc;
    bit  is_wr, stalled, done;
    logic g;
    rk = 0; grants = 0; out_cnt = 0; max_out = 0; stall_n = 0;
    stalled = 1'b0; done = 1'b0; exp_line = '0; prev = '0;
    is_wr = |strb;
    for (int i = 0; i < 4; i++) begin
      s = strb[i*4 +: 4];
      if (!is_wr || s != 4'h0)
        expq.push_back('{we: is_wr, be: (is_wr ? s : 4'hF),
                         addr: (addr & ~32'hF) + 32'(i * 4), wd: wd[i*32 +: 32]});
    end
    n_beats = expq.size();

    @(negedge clk_i);
    iomem_valid_i = 1'b1;
    iomem_addr_i  = addr;
    iomem_wstrb_i = strb;
    iomem_wdata_i = wd;
    bus_gnt_i     = 1'b0;
    bus_rvalid_i  = 1'b0;
    #1 check("accept_cycle_quiet", {iomem_ready_o, bus_req_o}, 2'b00);

    for (cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk_i);
      #1;
      cur = '{we: bus_we_o, be: bus_be_o, addr: bus_addr_o, wd: bus_wdata_o};
      if (stalled) check("stall_hold", {bus_req_o, cur}, {1'b1, prev});
      if (iomem_ready_o) begin
        check("rdata", iomem_rdata_o, is_wr ? 128'h0 : exp_line);
        check("beat_count", grants, n_beats);
        check("outstanding_bound", max_out <= out_lim, 1'b1);
        if (exp_lat >= 0) check("latency", cyc, exp_lat);
        last_rdata   = iomem_rdata_o;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        done = 1'b1;
      end else begin
        case (gnt_mode)
          0: g = 1'b1;
          1: g = 1'($urandom_range(0, 1));
          default: begin
            g = 1'b1;
            if (bus_req_o && grants == 2 && stall_n < 3) begin
              g = 1'b0;
              stall_n++;
            end
          end
        endcase
        bus_gnt_i = g;
        if (bus_req_o && g) begin
          if (expq.size() == 0) fail_now("unexpected_beat", grants + 1, n_beats);
          else check("beat_fields", cur, expq.pop_front());
          grants++;
          ex = (rv_extra < 0) ? int'($urandom_range(0, 2)) : rv_extra;
          pend.push_back('{due: cyc + 1 + ex,
                           data: fixed_data ? 32'hA0 + 32'(grants - 1) : $urandom()});
          out_cnt++;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          r = pend.pop_front();
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = r.data;
          if (!is_wr) exp_line[rk*32 +: 32] = r.data;
          rk++;
          out_cnt--;
        end else begin
          bus_rvalid_i = 1'b0;
          bus_rdata_i  = $urandom();
        end
        if (out_cnt > max_out) max_out = out_cnt;
        stalled = bus_req_o && !g;
        prev    = cur;
        if (abort_after > 0 && grants == abort_after) done = 1'b1;
      end
    end
    if (!done) fail_now("ready_timeout", cyc, 300);
  endtask

  initial begin
    logic [15:0]  rs;
    logic [127:0] rw;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 check("reset_outputs", all_outs, '0);
    rst_i = 1'b0;

    // Zero-wait read at 0x1004: words A0..A3, ready at cycle 6.
    run_line(32'h0000_1004, 16'h0, {4{32'h5555_AAAA}}, 0, 0, 1'b1, 6, 1, 0);
    check("read_line_const", last_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    idle(2);

    // Sparse write (one beat), then a read presented the cycle after ready.
    run_line(32'h0000_2000, 16'h00F0, {$urandom(), $urandom(), 32'hDEADBEEF, $urandom()},
             0, 0, 1'b0, -1, 2, 0);
    check("write_rdata_zero", last_rdata, 128'h0);
    run_line(32'h0000_3008, 16'h0, {$urandom(), $urandom(), $urandom(), $urandom()},
             0, 0, 1'b0, 6, 1, 0);
    idle(1);

    // Read with beat 2 stalled for 3 cycles and responses 2 cycles late.
    run_line(32'h0000_4000, 16'h0, '0, 2, 2, 1'b0, -1, MAX_OUTST, 0);
    idle(1);

    // Reset after two granted beats, then two late responses.
    run_line(32'h0000_5000, 16'h0, '0, 0, 6, 1'b0, -1, MAX_OUTST, 2);
    @(negedge clk_i);
    rst_i = 1'b1; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; iomem_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("abort_reset_outputs", all_outs, '0);
    repeat (2) begin
      @(negedge clk_i);
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = $urandom();
      #1 check("late_rvalid_quiet", all_outs, '0);
    end
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    #1 check("late_rvalid_after", all_outs, '0);
    run_line(32'h0000_600C, 16'h0, '0, 0, 0, 1'b0, 6, 1, 0);
    idle(1);

    // Same-cycle grant and response throughout: outstanding stays at 1.
    run_line(32'h0000_7000, 16'h0, '0, 0, 0, 1'b0, 6, 1, 0);

    // Randomized lines, random grants and response delays.
    for (int t = 0; t < 24; t++) begin
      rs = '0;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 3))
            0:       rs[i*4 +: 4] = 4'h0;
            1:       rs[i*4 +: 4] = 4'hF;
            default: rs[i*4 +: 4] = 4'($urandom());
          endcase
        end
      end
      rw = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_line($urandom(), rs, rw, 1, -1, 1'b0, -1, MAX_OUTST, 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
